// File: rtl/controle_andar.sv
// controle_andar: elevator car motion controller with collective up/down sweep.
// Latency: call latched 1 cycle after chamada; departure 1 cycle after latch; TEMPO_ANDAR cycles per floor.
// Backpressure: car only leaves PARADO with mover=1 and waits in ABRINDO/PORTA for the door-timer handshake.
// Optional feature: define RETORNO_TERREO_EN to send an idle car back to floor 0 after TEMPO_RETORNO cycles.
module controle_andar #(
  parameter int NUM_ANDARES   = 4,
  parameter int TEMPO_ANDAR   = 3,
  parameter int TEMPO_RETORNO = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_ANDARES-1:0]         chamada,
  input  logic                           mover,
  output logic                           chegada,
  output logic                           estadomover,
  output logic [$clog2(NUM_ANDARES)-1:0] andar_atual,
  output logic                           subindo,
  output logic [NUM_ANDARES-1:0]         pendentes
);

  localparam int W  = $clog2(NUM_ANDARES);
  localparam int TW = (TEMPO_ANDAR > 1) ? $clog2(TEMPO_ANDAR) : 1;
  localparam logic [TW-1:0] TA_MAX = TW'(TEMPO_ANDAR - 1);
  localparam logic [W-1:0]  TOPO   = W'(NUM_ANDARES - 1);

  // Parameter sanity: reject configurations the controller cannot honour.
  if (NUM_ANDARES < 2 || TEMPO_ANDAR < 1 || TEMPO_RETORNO < 1) begin : g_param_invalid
    $error("controle_andar: NUM_ANDARES>=2, TEMPO_ANDAR>=1, TEMPO_RETORNO>=1 required");
  end

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    MOVENDO = 2'd1,
    ABRINDO = 2'd2,
    PORTA   = 2'd3
  } estado_t;

  estado_t                estado;
  logic [TW-1:0]          cont;
  logic [NUM_ANDARES-1:0] retorno;
  logic [NUM_ANDARES-1:0] pend_mais;
  logic [NUM_ANDARES-1:0] limpa_atual;
  logic [NUM_ANDARES-1:0] limpa_prox;
  logic [W-1:0]           prox;
  logic                   acima;
  logic                   abaixo;

  // Direction is pinned at the shaft ends so the car can never step outside the floor range.
  function automatic logic dir_em(input logic [W-1:0] andar, input logic dir);
    if (andar == TOPO) begin
      return 1'b0;
    end else if (andar == '0) begin
      return 1'b1;
    end else begin
      return dir;
    end
  endfunction

  // Latched calls plus this cycle's presses; the served floor's bit is dropped so a stop absorbs a same-cycle press.
  always_comb begin
    pend_mais   = pendentes | chamada | retorno;
    prox        = subindo ? (andar_atual + W'(1)) : (andar_atual - W'(1));
    limpa_atual = pend_mais & ~(NUM_ANDARES'(1) << andar_atual);
    limpa_prox  = pend_mais & ~(NUM_ANDARES'(1) << prox);
  end

  // Which side of the car has latched calls, strictly beyond the current floor.
  always_comb begin
    acima  = 1'b0;
    abaixo = 1'b0;
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (pendentes[i] && (W'(i) > andar_atual)) acima  = 1'b1;
      if (pendentes[i] && (W'(i) < andar_atual)) abaixo = 1'b1;
    end
  end

`ifdef RETORNO_TERREO_EN
  localparam int RW = (TEMPO_RETORNO > 1) ? $clog2(TEMPO_RETORNO) : 1;
  localparam logic [RW-1:0] TR_MAX = RW'(TEMPO_RETORNO - 1);

  logic [RW-1:0] ocioso;
  logic          ocioso_cond;

  assign ocioso_cond = (estado == PARADO) && (pendentes == '0) && (chamada == '0) && (andar_atual != '0);
  assign retorno     = {{(NUM_ANDARES-1){1'b0}}, ocioso_cond && (ocioso == TR_MAX)};

  // Idle counter: runs only while parked away from floor 0 with nothing to do; any call or departure clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ocioso <= '0;
    end else if (!ocioso_cond || (ocioso == TR_MAX)) begin
      ocioso <= '0;
    end else begin
      ocioso <= ocioso + RW'(1);
    end
  end
`else
  assign retorno = '0;
`endif

  // Main controller: call latching, sweep scheduling, floor travel and door handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= PARADO;
      cont        <= '0;
      andar_atual <= '0;
      subindo     <= 1'b1;
      pendentes   <= '0;
      chegada     <= 1'b0;
      estadomover <= 1'b0;
    end else begin
      chegada   <= 1'b0;
      pendentes <= pend_mais;
      case (estado)
        PARADO: begin
          cont        <= '0;
          estadomover <= 1'b0;
          if (pendentes[andar_atual]) begin
            // Call at the floor we are parked on: re-open the door without moving.
            pendentes <= limpa_atual;
            chegada   <= 1'b1;
            estado    <= ABRINDO;
          end else if (subindo ? acima : abaixo) begin
            if (mover) begin
              estado      <= MOVENDO;
              estadomover <= 1'b1;
            end
          end else if (acima || abaixo) begin
            // Nothing ahead but work behind: reverse now, depart next cycle.
            subindo <= ~subindo;
          end
        end
        MOVENDO: begin
          if (cont == TA_MAX) begin
            cont        <= '0;
            andar_atual <= prox;
            subindo     <= dir_em(prox, subindo);
            if (pend_mais[prox]) begin
              pendentes   <= limpa_prox;
              chegada     <= 1'b1;
              estadomover <= 1'b0;
              estado      <= ABRINDO;
            end
          end else begin
            cont <= cont + TW'(1);
          end
        end
        ABRINDO: begin
          // Door timer acknowledges the arrival by dropping mover.
          if (!mover) estado <= PORTA;
        end
        PORTA: begin
          if (mover) estado <= PARADO;
        end
        default: begin
          estado <= PARADO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_andar.sv
// tb_controle_andar: directed vectors for the elevator motion controller.
// Default parameters: 4 floors, 3 cycles per floor, 16-cycle return timeout.
// Return-to-ground expectations follow whether RETORNO_TERREO_EN is defined.
module tb_controle_andar;

  logic       clock;
  logic       reset;
  logic [3:0] chamada;
  logic       mover;
  logic       chegada;
  logic       estadomover;
  logic [1:0] andar_atual;
  logic       subindo;
  logic [3:0] pendentes;

  int vetores = 0;
  int erros   = 0;

  controle_andar #(
    .NUM_ANDARES  (4),
    .TEMPO_ANDAR  (3),
    .TEMPO_RETORNO(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .chamada    (chamada),
    .mover      (mover),
    .chegada    (chegada),
    .estadomover(estadomover),
    .andar_atual(andar_atual),
    .subindo    (subindo),
    .pendentes  (pendentes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vetores++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  initial begin
    reset   = 1'b1;
    mover   = 1'b1;
    chamada = 4'b0000;
    tick(2);
    confere("rst_andar", 32'(andar_atual), 32'd0);
    confere("rst_subindo", 32'(subindo), 32'd1);
    confere("rst_pend", 32'(pendentes), 32'd0);
    confere("rst_chegada", 32'(chegada), 32'd0);
    confere("rst_estmov", 32'(estadomover), 32'd0);

    // Single trip 0 -> 2: cycle 0 press
    reset   = 1'b0;
    chamada = 4'b0100;
    tick();                                    // cycle 1
    chamada = 4'b0000;
    confere("trip_pend_c1", 32'(pendentes), 32'b0100);
    confere("trip_estmov_c1", 32'(estadomover), 32'd0);
    tick();                                    // cycle 2
    confere("trip_estmov_c2", 32'(estadomover), 32'd1);
    confere("trip_andar_c2", 32'(andar_atual), 32'd0);
    tick(2);                                   // cycle 4
    confere("trip_andar_c4", 32'(andar_atual), 32'd0);
    tick();                                    // cycle 5
    confere("trip_andar_c5", 32'(andar_atual), 32'd1);
    confere("trip_chegada_c5", 32'(chegada), 32'd0);
    tick(2);                                   // cycle 7
    confere("trip_andar_c7", 32'(andar_atual), 32'd1);
    tick();                                    // cycle 8
    confere("trip_andar_c8", 32'(andar_atual), 32'd2);
    confere("trip_chegada_c8", 32'(chegada), 32'd1);
    confere("trip_estmov_c8", 32'(estadomover), 32'd0);
    confere("trip_pend_c8", 32'(pendentes), 32'd0);
    tick();                                    // cycle 9
    confere("trip_chegada_c9", 32'(chegada), 32'd0);

    // Door handshake with no calls: hold in ABRINDO, then 0 -> 1 back to PARADO
    tick(4);
    confere("door_hold_estmov", 32'(estadomover), 32'd0);
    confere("door_hold_andar", 32'(andar_atual), 32'd2);
    mover = 1'b0;
    tick(3);
    confere("door_low_estmov", 32'(estadomover), 32'd0);
    mover = 1'b1;
    tick();                                    // now PARADO at floor 2
    confere("door_back_estmov", 32'(estadomover), 32'd0);

    // Current-floor call while parked at floor 2
    chamada = 4'b0100;
    tick();
    chamada = 4'b0000;
    confere("cur_pend", 32'(pendentes), 32'b0100);
    confere("cur_chegada_latch", 32'(chegada), 32'd0);
    tick();
    confere("cur_chegada", 32'(chegada), 32'd1);
    confere("cur_pend_clr", 32'(pendentes), 32'd0);
    confere("cur_estmov", 32'(estadomover), 32'd0);
    tick();
    confere("cur_chegada_end", 32'(chegada), 32'd0);

    // In ABRINDO with a new call and mover still 1: the car must not leave
    chamada = 4'b1000;
    tick();
    chamada = 4'b0000;
    confere("abr_pend", 32'(pendentes), 32'b1000);
    tick(3);
    confere("abr_no_move", 32'(estadomover), 32'd0);
    mover = 1'b0;
    tick(2);
    confere("porta_no_move", 32'(estadomover), 32'd0);
    mover = 1'b1;
    tick();                                    // PARADO
    confere("porta_parado_estmov", 32'(estadomover), 32'd0);
    tick();                                    // departure
    confere("dep_estmov", 32'(estadomover), 32'd1);
    confere("dep_andar", 32'(andar_atual), 32'd2);
    tick(3);
    confere("top_andar", 32'(andar_atual), 32'd3);
    confere("top_chegada", 32'(chegada), 32'd1);
    confere("top_subindo", 32'(subindo), 32'd0);

    // Sweep order: car at floor 1 going up, calls at 0 and 3
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    chamada = 4'b0010;
    tick();
    chamada = 4'b0000;
    tick(4);                                   // cycle 5: arrival at floor 1
    confere("sw_andar1", 32'(andar_atual), 32'd1);
    confere("sw_chegada1", 32'(chegada), 32'd1);
    confere("sw_subindo1", 32'(subindo), 32'd1);
    chamada = 4'b1001;
    tick();
    chamada = 4'b0000;
    confere("sw_pend", 32'(pendentes), 32'b1001);
    mover = 1'b0;
    tick(2);
    mover = 1'b1;
    tick();                                    // PARADO
    tick();                                    // departure upwards
    confere("sw_dep_up", 32'(estadomover), 32'd1);
    tick(3);
    confere("sw_pass2_andar", 32'(andar_atual), 32'd2);
    confere("sw_pass2_chegada", 32'(chegada), 32'd0);
    confere("sw_pass2_estmov", 32'(estadomover), 32'd1);
    tick(3);
    confere("sw_stop3_andar", 32'(andar_atual), 32'd3);
    confere("sw_stop3_chegada", 32'(chegada), 32'd1);
    confere("sw_stop3_subindo", 32'(subindo), 32'd0);
    confere("sw_stop3_pend", 32'(pendentes), 32'b0001);
    mover = 1'b0;
    tick();
    mover = 1'b1;
    tick();                                    // PARADO at 3
    tick();                                    // departure downwards
    confere("sw_dep_down", 32'(estadomover), 32'd1);
    tick(3);
    confere("sw_down2_andar", 32'(andar_atual), 32'd2);
    confere("sw_down2_estmov", 32'(estadomover), 32'd1);

    // Mid-travel reset while heading for floor 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    confere("mid_rst_andar", 32'(andar_atual), 32'd0);
    confere("mid_rst_pend", 32'(pendentes), 32'd0);
    confere("mid_rst_estmov", 32'(estadomover), 32'd0);
    confere("mid_rst_chegada", 32'(chegada), 32'd0);
    confere("mid_rst_subindo", 32'(subindo), 32'd1);

    // Park at floor 3 and watch idle behaviour
    chamada = 4'b1000;
    tick();                                    // cycle 1
    chamada = 4'b0000;
    tick();                                    // cycle 2
    tick(9);                                   // cycle 11
    confere("ret_arr_andar", 32'(andar_atual), 32'd3);
    confere("ret_arr_chegada", 32'(chegada), 32'd1);
    mover = 1'b0;
    tick();                                    // PORTA
    mover = 1'b1;
    tick();                                    // PARADO, first idle cycle
`ifdef RETORNO_TERREO_EN
    tick(15);                                  // 16th idle cycle
    confere("ret_idle_estmov", 32'(estadomover), 32'd0);
    confere("ret_idle_pend", 32'(pendentes), 32'd0);
    tick();
    confere("ret_set_pend", 32'(pendentes), 32'b0001);
    confere("ret_set_estmov", 32'(estadomover), 32'd0);
    tick();
    confere("ret_dep_estmov", 32'(estadomover), 32'd1);
    tick(9);
    confere("ret_ground_andar", 32'(andar_atual), 32'd0);
    confere("ret_ground_chegada", 32'(chegada), 32'd1);
    confere("ret_ground_pend", 32'(pendentes), 32'd0);
`else
    tick(100);
    confere("noret_andar", 32'(andar_atual), 32'd3);
    confere("noret_estmov", 32'(estadomover), 32'd0);
    confere("noret_pend", 32'(pendentes), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
